// File: rtl/base_r_pkg.sv
// Shared definitions for the 64b/66b BASE-R transmit encoder.
// Holds the MII control characters and their 7-bit codes, the block-type bytes,
// the sync headers, the TX FSM state enum and the block-class enum.
// It also has small helpers that map control characters to codes and select
// the terminate block type.
package base_r_pkg;

    // MII control characters
    localparam logic [7:0] CHAR_IDLE  = 8'h07;
    localparam logic [7:0] CHAR_ERROR = 8'hFE;
    localparam logic [7:0] CHAR_START = 8'hFB;
    localparam logic [7:0] CHAR_TERM  = 8'hFD;

    // 7-bit control codes carried inside control blocks
    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    // Block-type bytes
    localparam logic [7:0] BT_CTRL  = 8'h1E;
    localparam logic [7:0] BT_START = 8'h78;

    // Sync headers
    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic [2:0] {
        StInit,
        StC,
        StD,
        StT,
        StE
    } tx_state_e;

    typedef enum logic [2:0] {
        ClsC,
        ClsS,
        ClsT,
        ClsD,
        ClsE
    } blk_class_e;

    function automatic logic is_idle_or_err(input logic [7:0] ch);
        return (ch == CHAR_IDLE) || (ch == CHAR_ERROR);
    endfunction

    // Only valid for characters already known to be Idle or Error.
    function automatic logic [6:0] ctrl_code(input logic [7:0] ch);
        return (ch == CHAR_IDLE) ? CODE_IDLE : CODE_ERROR;
    endfunction

    function automatic logic [7:0] term_type(input logic [2:0] lane);
        logic [7:0] bt;
        case (lane)
            3'd0:    bt = 8'h87;
            3'd1:    bt = 8'h99;
            3'd2:    bt = 8'hAA;
            3'd3:    bt = 8'hB4;
            3'd4:    bt = 8'hCC;
            3'd5:    bt = 8'hD2;
            3'd6:    bt = 8'hE1;
            default: bt = 8'hFF;
        endcase
        return bt;
    endfunction

endpackage

// File: rtl/base_r_block_classify.sv
// Combinational classifier for one 64-bit MII word.
// Ports:
//   i_txd       - eight MII data lanes, lane 0 in bits [7:0]
//   i_txc       - per-lane control flags
//   o_class     - block class: C, S, T, D or E
//   o_term_lane - lane holding Terminate; meaningful only when o_class == ClsT
module base_r_block_classify
    import base_r_pkg::*;
(
    input  logic [63:0] i_txd,
    input  logic [7:0]  i_txc,
    output blk_class_e  o_class,
    output logic [2:0]  o_term_lane
);

    logic [7:0] w_ie;  // lane holds Idle or Error

    always_comb begin
        w_ie = '0;
        for (int i = 0; i < 8; i++) begin
            w_ie[i] = is_idle_or_err(i_txd[8*i +: 8]);
        end
    end

    always_comb begin
        o_class     = ClsE;
        o_term_lane = 3'd0;
        if ((i_txc == 8'hFF) && (&w_ie)) begin
            o_class = ClsC;
        end else if ((i_txc == 8'h01) && (i_txd[7:0] == CHAR_START)) begin
            o_class = ClsS;
        end else if (i_txc == 8'h00) begin
            o_class = ClsD;
        end else begin
            // T(k): txc ones from lane k upward, Terminate in lane k, and only
            // Idle/Error above it. At most one k can match the txc pattern.
            for (int k = 0; k < 8; k++) begin
                if ((i_txc == (8'hFF << k)) && (i_txd[8*k +: 8] == CHAR_TERM) &&
                    (&(w_ie | ~(8'hFE << k)))) begin
                    o_class     = ClsT;
                    o_term_lane = 3'(k);
                end
            end
        end
    end

endmodule

// File: rtl/base_r_encoder_64b66b.sv
// 64b/66b BASE-R transmit encoder with a one-cycle registered output.
// Ports:
//   clk          - clock; all state changes on its rising edge
//   i_rst        - synchronous active-high reset
//   i_valid      - qualifies i_txd/i_txc this cycle
//   i_txd, i_txc - 64-bit MII data and 8-bit control
//   o_valid      - o_tx_coded holds a new block
//   o_tx_coded   - {sync header, 64-bit payload}; block type in [7:0]
//   o_err_blocks - saturating count of error blocks emitted
module base_r_encoder_64b66b
    import base_r_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [63:0]          i_txd,
    input  logic [7:0]           i_txc,
    output logic                 o_valid,
    output logic [65:0]          o_tx_coded,
    output logic [ERR_CNT_W-1:0] o_err_blocks
);

    localparam logic [63:0] ERR_PAYLOAD = {{8{CODE_ERROR}}, BT_CTRL};
    localparam logic [65:0] RST_BLOCK   = {SH_CTRL, 56'h0, BT_CTRL};

    blk_class_e           w_class;
    logic [2:0]           w_term_lane;
    tx_state_e            r_state;
    tx_state_e            w_state_next;
    logic [1:0]           w_sync;
    logic [63:0]          w_payload;
    logic                 r_valid;
    logic [65:0]          r_tx_coded;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    base_r_block_classify u_classify (
        .i_txd       (i_txd),
        .i_txc       (i_txc),
        .o_class     (w_class),
        .o_term_lane (w_term_lane)
    );

    always_comb begin
        w_state_next = StE;
        case (r_state)
            StD: begin
                case (w_class)
                    ClsD:    w_state_next = StD;
                    ClsT:    w_state_next = StT;
                    default: w_state_next = StE;
                endcase
            end
            StE: begin
                case (w_class)
                    ClsC:    w_state_next = StC;
                    ClsS:    w_state_next = StD;
                    ClsD:    w_state_next = StD;
                    ClsT:    w_state_next = StT;
                    default: w_state_next = StE;
                endcase
            end
            default: begin  // StInit, StC, StT
                case (w_class)
                    ClsC:    w_state_next = StC;
                    ClsS:    w_state_next = StD;
                    default: w_state_next = StE;
                endcase
            end
        endcase
    end

    // The block is chosen by the state being entered: an error block whenever
    // the FSM lands in E, otherwise the encoding of the current word.
    always_comb begin
        w_sync    = SH_CTRL;
        w_payload = ERR_PAYLOAD;
        if (w_state_next != StE) begin
            case (w_class)
                ClsD: begin
                    w_sync    = SH_DATA;
                    w_payload = i_txd;
                end
                ClsS: w_payload = {i_txd[63:8], BT_START};
                ClsC: begin
                    w_payload      = '0;
                    w_payload[7:0] = BT_CTRL;
                    for (int i = 0; i < 8; i++) begin
                        w_payload[7*i+8 +: 7] = ctrl_code(i_txd[8*i +: 8]);
                    end
                end
                ClsT: begin
                    // Data shifts up one byte past the type; trailing codes
                    // keep the same bit slots as in a C block; the gap stays zero.
                    w_payload      = '0;
                    w_payload[7:0] = term_type(w_term_lane);
                    for (int i = 0; i < 7; i++) begin
                        if (i < int'(w_term_lane)) begin
                            w_payload[8*i+8 +: 8] = i_txd[8*i +: 8];
                        end
                    end
                    for (int i = 1; i < 8; i++) begin
                        if (i > int'(w_term_lane)) begin
                            w_payload[7*i+8 +: 7] = ctrl_code(i_txd[8*i +: 8]);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= StInit;
        end else if (i_valid) begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_valid    <= 1'b0;
            r_tx_coded <= RST_BLOCK;
            r_err_cnt  <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_tx_coded <= {w_sync, w_payload};
                if ((w_state_next == StE) && (r_err_cnt != '1)) begin
                    r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign o_valid      = r_valid;
    assign o_tx_coded   = r_tx_coded;
    assign o_err_blocks = r_err_cnt;

endmodule

// File: tb/tb_base_r_encoder_64b66b.sv
// Directed bench for base_r_encoder_64b66b: two instances share the stimulus,
// the default one and one with a 2-bit error counter for saturation.
module tb_base_r_encoder_64b66b;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [63:0] i_txd;
    logic [7:0]  i_txc;
    logic        o_valid;
    logic [65:0] o_tx_coded;
    logic [15:0] o_err_blocks;
    logic        o_valid2;
    logic [65:0] o_tx_coded2;
    logic [1:0]  o_err_blocks2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    base_r_encoder_64b66b u_dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_txd        (i_txd),
        .i_txc        (i_txc),
        .o_valid      (o_valid),
        .o_tx_coded   (o_tx_coded),
        .o_err_blocks (o_err_blocks)
    );

    base_r_encoder_64b66b #(.ERR_CNT_W(2)) u_dut_sat (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_txd        (i_txd),
        .i_txc        (i_txc),
        .o_valid      (o_valid2),
        .o_tx_coded   (o_tx_coded2),
        .o_err_blocks (o_err_blocks2)
    );

    // Expected blocks, hand-encoded.
    localparam logic [65:0] BLK_RST   = {2'b10, 64'h0000_0000_0000_001E};
    localparam logic [65:0] BLK_CIDLE = {2'b10, 64'h0000_0000_0000_001E};
    localparam logic [65:0] BLK_CERR0 = {2'b10, 64'h0000_0000_0000_1E1E};
    localparam logic [65:0] BLK_ERR   = {2'b10, 64'h3C78_F1E3_C78F_1E1E};
    localparam logic [65:0] BLK_S     = {2'b10, 64'hD555_5555_5555_5578};
    localparam logic [65:0] BLK_D1    = {2'b01, 64'h0123_4567_89AB_CDEF};
    localparam logic [65:0] BLK_D2    = {2'b01, 64'hFEDC_BA98_7654_3210};
    localparam logic [65:0] BLK_T3    = {2'b10, 64'h0000_0000_3332_31B4};
    localparam logic [65:0] BLK_T7    = {2'b10, 64'h6655_4433_2211_00FF};
    localparam logic [65:0] BLK_T0    = {2'b10, 64'h3C00_0000_000F_0087};

    localparam logic [63:0] W_IDLE  = 64'h0707_0707_0707_0707;
    localparam logic [63:0] W_CERR0 = 64'h0707_0707_0707_07FE;
    localparam logic [63:0] W_S     = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] W_D1    = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W_D2    = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] W_T3    = 64'h0707_0707_FD33_3231;
    localparam logic [63:0] W_T7    = 64'hFD66_5544_3322_1100;
    localparam logic [63:0] W_T0    = 64'hFE07_0707_0707_FEFD;

    task automatic check_eq(input string tag, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Drive one cycle; outputs sampled 1 time unit after the edge reflect it.
    task automatic step(input logic rst, input logic vld, input logic [63:0] d,
                        input logic [7:0] c);
        i_rst   = rst;
        i_valid = vld;
        i_txd   = d;
        i_txc   = c;
        @(posedge clk);
        #1;
    endtask

    // Five different malformed words, all classed E from INIT.
    logic [63:0] e_txd [5];
    logic [7:0]  e_txc [5];
    logic [15:0] exp_cnt  [5];
    logic [1:0]  exp_cnt2 [5];

    initial begin
        e_txd[0] = 64'h1234_5678_9ABC_DEF0; e_txc[0] = 8'h55;
        e_txd[1] = 64'h0000_00FB_0000_0000; e_txc[1] = 8'h10;  // Start in lane 4
        e_txd[2] = 64'h0000_0000_0000_0000; e_txc[2] = 8'hFF;  // control, not Idle
        e_txd[3] = 64'h1111_1111_1111_11AA; e_txc[3] = 8'h01;  // S flag, no Start
        e_txd[4] = 64'h0707_0007_FD33_3231; e_txc[4] = 8'hF8;  // bad lane after T
        exp_cnt[0]  = 16'd1; exp_cnt[1]  = 16'd2; exp_cnt[2]  = 16'd3;
        exp_cnt[3]  = 16'd4; exp_cnt[4]  = 16'd5;
        exp_cnt2[0] = 2'd1;  exp_cnt2[1] = 2'd2;  exp_cnt2[2] = 2'd3;
        exp_cnt2[3] = 2'd3;  exp_cnt2[4] = 2'd3;

        i_rst = 1'b1; i_valid = 1'b0; i_txd = '0; i_txc = '0;

        // Reset dominates a valid word.
        step(1'b1, 1'b1, W_D1, 8'h00);
        step(1'b1, 1'b1, W_D1, 8'h00);
        check_eq("rst_valid", 66'(o_valid), 66'(1'b0));
        check_eq("rst_coded", o_tx_coded, BLK_RST);
        check_eq("rst_err", 66'(o_err_blocks), 66'd0);

        // Idle C block, then C with an Error lane.
        step(1'b0, 1'b1, W_IDLE, 8'hFF);
        check_eq("c_idle_valid", 66'(o_valid), 66'(1'b1));
        check_eq("c_idle", o_tx_coded, BLK_CIDLE);
        step(1'b0, 1'b1, W_CERR0, 8'hFF);
        check_eq("c_err_lane", o_tx_coded, BLK_CERR0);

        // S, D, D, T(3), C
        step(1'b0, 1'b1, W_S, 8'h01);
        check_eq("frame_s", o_tx_coded, BLK_S);
        step(1'b0, 1'b1, W_D1, 8'h00);
        check_eq("frame_d1", o_tx_coded, BLK_D1);
        step(1'b0, 1'b1, W_D2, 8'h00);
        check_eq("frame_d2", o_tx_coded, BLK_D2);
        step(1'b0, 1'b1, W_T3, 8'hF8);
        check_eq("frame_t3", o_tx_coded, BLK_T3);
        step(1'b0, 1'b1, W_IDLE, 8'hFF);
        check_eq("frame_c", o_tx_coded, BLK_CIDLE);
        check_eq("frame_err", 66'(o_err_blocks), 66'd0);

        // D before any S after reset -> error block, then normal C.
        step(1'b1, 1'b0, '0, 8'h00);
        step(1'b0, 1'b1, W_D1, 8'h00);
        check_eq("init_d_blk", o_tx_coded, BLK_ERR);
        check_eq("init_d_err", 66'(o_err_blocks), 66'd1);
        step(1'b0, 1'b1, W_IDLE, 8'hFF);
        check_eq("init_d_then_c", o_tx_coded, BLK_CIDLE);
        check_eq("init_d_then_c_err", 66'(o_err_blocks), 66'd1);

        // Valid gap mid-frame, then T(7).
        step(1'b0, 1'b1, W_S, 8'h01);
        check_eq("gap_s", o_tx_coded, BLK_S);
        step(1'b0, 1'b0, 64'hDEAD_BEEF_0000_0000, 8'h55);
        check_eq("gap_valid", 66'(o_valid), 66'(1'b0));
        check_eq("gap_held", o_tx_coded, BLK_S);
        step(1'b0, 1'b1, W_D1, 8'h00);
        check_eq("gap_valid_back", 66'(o_valid), 66'(1'b1));
        check_eq("gap_d1", o_tx_coded, BLK_D1);
        step(1'b0, 1'b1, W_T7, 8'h80);
        check_eq("t7", o_tx_coded, BLK_T7);

        // S then T(0) with mixed Idle/Error trailing lanes.
        step(1'b0, 1'b1, W_S, 8'h01);
        step(1'b0, 1'b1, W_T0, 8'hFF);
        check_eq("t0", o_tx_coded, BLK_T0);
        check_eq("t0_err", 66'(o_err_blocks), 66'd1);

        // Reset mid-frame restarts in INIT.
        step(1'b0, 1'b1, W_S, 8'h01);
        step(1'b0, 1'b1, W_D1, 8'h00);
        step(1'b1, 1'b1, W_D2, 8'h00);
        check_eq("midrst_valid", 66'(o_valid), 66'(1'b0));
        check_eq("midrst_coded", o_tx_coded, BLK_RST);
        step(1'b0, 1'b1, W_D2, 8'h00);
        check_eq("midrst_d_blk", o_tx_coded, BLK_ERR);
        check_eq("midrst_d_err", 66'(o_err_blocks), 66'd1);

        // Error run: saturation on the 2-bit instance.
        step(1'b1, 1'b0, '0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, e_txd[i], e_txc[i]);
            check_eq($sformatf("erun%0d_blk", i), o_tx_coded2, BLK_ERR);
            check_eq($sformatf("erun%0d_cnt", i), 66'(o_err_blocks), 66'(exp_cnt[i]));
            check_eq($sformatf("erun%0d_sat", i), 66'(o_err_blocks2), 66'(exp_cnt2[i]));
        end

        // E -> D is allowed.
        step(1'b0, 1'b1, W_D2, 8'h00);
        check_eq("e_to_d", o_tx_coded, BLK_D2);
        check_eq("e_to_d_cnt", 66'(o_err_blocks), 66'd5);
        check_eq("e_to_d_valid2", 66'(o_valid2), 66'(1'b1));

        // Reset clears both counters.
        step(1'b1, 1'b1, W_D1, 8'h00);
        check_eq("rst_cnt", 66'(o_err_blocks), 66'd0);
        check_eq("rst_cnt_sat", 66'(o_err_blocks2), 66'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/base_r_encoder_64b66b.md
BASE_R_ENCODER_64B66B -- requirements
Module: base_r_encoder_64b66b

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 16, width of the saturating error-block counter.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  qualifies i_txd/i_txc for this cycle; driven from upstream o_txValid.
REQ-005 SHALL have port i_txd  input  64  MII data; lane k = i_txd[8k+7:8k], lane 0 first in time.
REQ-006 SHALL have port i_txc  input  8  MII control; i_txc[k]=1 marks lane k as a control character.
REQ-007 SHALL have port o_valid  output  1  o_tx_coded holds a new block.
REQ-008 SHALL have port o_tx_coded  output  66  [65:64] sync header, [63:0] block payload, block type in [7:0].
REQ-009 SHALL have port o_err_blocks  output  ERR_CNT_W  count of error blocks emitted, saturating.

Function
REQ-010 SHALL recognise control chars: Idle 0x07 (7-bit code 0x00), Error 0xFE (code 0x1E), Start 0xFB, Terminate 0xFD.
REQ-011 SHALL classify each valid word as exactly one of:
 - C: i_txc=8'hFF, every lane Idle or Error.
 - S: i_txc=8'h01, lane0=Start.
 - T(k), k=0..7: lanes <k data (txc=0), lane k Terminate (txc=1), lanes >k Idle/Error (txc=1).
 - D: i_txc=8'h00.
 - E: anything else, including Start in lane 4.
REQ-012 SHALL use sync header 2'b01 for D blocks and 2'b10 for all other blocks.
REQ-013 SHALL encode D as payload = i_txd unchanged.
REQ-014 SHALL encode C as type 0x1E, lane i 7-bit code at bits [8+7i+6:8+7i].
REQ-015 SHALL encode S as type 0x78, lanes 1..7 at bits [8i+7:8i].
REQ-016 SHALL encode T(k) with type 0x87,0x99,0xAA,0xB4,0xCC,0xD2,0xE1,0xFF for k=0..7.
REQ-017 SHALL pack T(k) as: data lane i at [8i+15:8i+8]; codes for lanes k+1..7 packed in the top 7*(7-k) bits, lane 7 highest; gap bits zero.
REQ-018 SHALL emit error block (type 0x1E, all eight codes 0x1E) whenever the FSM enters or stays in E.
REQ-019 SHALL run TX FSM with states INIT, C, D, T, E, advancing only on valid words.
REQ-020 FSM transitions:
 - INIT/C/T: C->C, S->D, else E.
 - D: D->D, T(k)->T, else E.
 - E: C->C, S->D, D->D, T(k)->T, else E.
REQ-021 SHALL output the encoding of the classified word in states C, D, T; SHALL output the error block in state E.
REQ-022 SHALL have latency exactly 1 cycle: o_valid(n+1)=i_valid(n); o_tx_coded reflects word n.
REQ-023 SHALL, when i_valid=0, keep FSM state and o_tx_coded unchanged and drive o_valid=0.
REQ-024 SHALL increment o_err_blocks once per emitted error block and hold at all-ones.

Reset
REQ-025 SHALL, while i_rst=1, set FSM=INIT, o_valid=0, o_tx_coded={2'b10,56'h0,8'h1E}, o_err_blocks=0.
REQ-026 SHALL let reset dominate i_valid in the same cycle; a word presented under reset is discarded.
REQ-027 SHALL, on reset mid-frame, restart in INIT, so a following D word yields an error block.

Structure
REQ-028 SHALL place in shared package base_r_pkg:
 - control-char constants and 7-bit codes;
 - block-type constants;
 - sync-header constants;
 - FSM state enum;
 - block-class enum (C,S,T,D,E) plus terminate lane index.
REQ-029 SHALL implement classification in one combinational sub-module base_r_block_classify (i_txd, i_txc -> class, term lane); encoder core holds FSM, packing, output registers, counter.

Verification
REQ-030 Reset then valid txc=FF, txd=all 0x07 -> next cycle o_valid=1, o_tx_coded={2'b10,56'h0,8'h1E}.
REQ-031 Frame: S (txd=D5555555555555FB, txc=01), D x2, T(3) (txd=0707_0707_FD_333231, txc=F8) -> types 0x78, data x2, 0xB4; data 31,32,33 in [15:8],[23:16],[31:24]; bits [63:32]=0; o_err_blocks=0.
REQ-032 After reset, D word before any S -> error block, o_err_blocks=1; then C -> normal C block.
REQ-033 i_valid toggled 1,0,1 mid-frame -> o_valid 1,0,1 one cycle later; o_tx_coded held; sequence encodes as if contiguous.
REQ-034 T(7) (txc=80, lane7=FD) -> type 0xFF, lanes 0..6 at [63:8]; T(0) (txc=FF, lane0=FD) -> type 0x87, lane1..7 codes in [63:15], [14:8]=0.
REQ-035 ERR_CNT_W=2, five consecutive E words -> o_err_blocks 1,2,3,3,3; i_rst mid-run -> 0.
